// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
//
// Serial-in, parallel-out sample collector for the FFT input. Samples are
// shifted into a DEPTH x WIDTH chain. When a frame of DEPTH samples is
// complete, it is copied into a held output bank. The bank can be presented
// in natural order or in bit-reversed order (radix-2 DIT input order). A
// valid/ack handshake hands each frame to the FFT core. A sticky overflow
// flag records a frame that completed while the previous one was still
// unacknowledged.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   in_data      in   [WIDTH]        input sample
//   in_valid     in                  sample strobe
//   clear        in                  synchronous flush of collector, valid, overflow
//   frame_ack    in                  consumer has taken the current frame
//   frame_data   out  [DEPTH*WIDTH]  held frame, slot k = [k*WIDTH +: WIDTH]
//   frame_valid  out                 frame_data holds an unacknowledged frame
//   fill_count   out  [CNT_W]        samples in the current partial frame
//   overflow     out                 sticky overrun flag
// ---------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int BIT_REVERSE = 0,
    parameter int CNT_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   clear,
    input  logic                   frame_ack,
    output logic [DEPTH*WIDTH-1:0] frame_data,
    output logic                   frame_valid,
    output logic [CNT_W-1:0]       fill_count,
    output logic                   overflow
);

    // Reverse the low CNT_W bits of a slot index.
    function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < CNT_W; i++) begin
            r[i] = idx[CNT_W-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0]       chain_r [DEPTH];
    logic [WIDTH-1:0]       chain_nxt_s [DEPTH];
    logic [DEPTH*WIDTH-1:0] frame_data_r;
    logic [DEPTH*WIDTH-1:0] frame_nxt_s;
    logic [WIDTH-1:0]       sample_s [DEPTH];
    logic [CNT_W-1:0]       fill_count_r;
    logic [CNT_W-1:0]       fill_nxt_s;
    logic                   frame_valid_r;
    logic                   valid_nxt_s;
    logic                   overflow_r;
    logic                   overflow_nxt_s;
    logic                   accept_s;
    logic                   complete_s;

    // clear overrides any sample offered in the same cycle.
    assign accept_s   = in_valid & ~clear;
    assign complete_s = accept_s && (fill_count_r == CNT_W'(DEPTH - 1));

    // Next state of the shift chain: stage 0 receives the newest sample.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            chain_nxt_s[i] = chain_r[i];
        end
        if (accept_s) begin
            chain_nxt_s[0] = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                chain_nxt_s[i] = chain_r[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_nxt_s[i] = chain_r[i];
            end
        end
    end

    // Arrange the completed frame in arrival order.
    // s[DEPTH-1] is the sample arriving now. s[j] for j < DEPTH-1 sits
    // DEPTH-2-j stages into the chain.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            sample_s[j] = '0;
        end
        sample_s[DEPTH-1] = in_data;
        for (int j = 0; j < DEPTH - 1; j++) begin
            sample_s[j] = chain_r[DEPTH-2-j];
        end
    end

    // Map arrival order to output slots, in natural or bit-reversed order.
    always_comb begin
        frame_nxt_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (BIT_REVERSE != 0) begin
                frame_nxt_s[k*WIDTH +: WIDTH] = sample_s[bitrev(CNT_W'(k))];
            end else begin
                frame_nxt_s[k*WIDTH +: WIDTH] = sample_s[k];
            end
        end
    end

    // Next state of the fill counter, handshake and overflow flag.
    always_comb begin
        fill_nxt_s     = fill_count_r;
        valid_nxt_s    = frame_valid_r;
        overflow_nxt_s = overflow_r;
        if (complete_s) begin
            fill_nxt_s  = '0;
            valid_nxt_s = 1'b1;
            // An ack on the completing edge consumes the old frame, so
            // this is not an overrun.
            if (frame_valid_r && !frame_ack) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
        end else if (accept_s) begin
            fill_nxt_s = fill_count_r + CNT_W'(1);
            if (frame_ack) begin
                valid_nxt_s = 1'b0;
            end else begin
                valid_nxt_s = frame_valid_r;
            end
        end else begin
            fill_nxt_s = fill_count_r;
            if (frame_ack) begin
                valid_nxt_s = 1'b0;
            end else begin
                valid_nxt_s = frame_valid_r;
            end
        end
    end

    // Shift-chain register; clear zeroes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_r[i] <= chain_nxt_s[i];
            end
        end
    end

    // Control registers: fill counter, frame valid and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_r  <= '0;
            frame_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else if (clear) begin
            fill_count_r  <= '0;
            frame_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            fill_count_r  <= fill_nxt_s;
            frame_valid_r <= valid_nxt_s;
            overflow_r    <= overflow_nxt_s;
        end
    end

    // Output bank: reloads only when a frame completes; clear leaves it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data_r <= '0;
        end else if (complete_s) begin
            frame_data_r <= frame_nxt_s;
        end else begin
            frame_data_r <= frame_data_r;
        end
    end

    assign frame_data  = frame_data_r;
    assign frame_valid = frame_valid_r;
    assign fill_count  = fill_count_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer. Two instances share the same
// stimulus: one in natural order and one in bit-reversed order.
module tb_fft_frame_buffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        clear;
    logic        frame_ack;
    logic [63:0] fd_n;
    logic [63:0] fd_r;
    logic        fv_n;
    logic        fv_r;
    logic [2:0]  fc_n;
    logic [2:0]  fc_r;
    logic        ov_n;
    logic        ov_r;

    int n_cmp = 0;
    int n_err = 0;

    fft_frame_buffer #(.WIDTH(8), .DEPTH(8), .BIT_REVERSE(0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .clear(clear), .frame_ack(frame_ack), .frame_data(fd_n),
        .frame_valid(fv_n), .fill_count(fc_n), .overflow(ov_n)
    );

    fft_frame_buffer #(.WIDTH(8), .DEPTH(8), .BIT_REVERSE(1)) dut_rev (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .clear(clear), .frame_ack(frame_ack), .frame_data(fd_r),
        .frame_valid(fv_r), .fill_count(fc_r), .overflow(ov_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slot 0 sits in the least-significant byte.
    function automatic logic [63:0] pk(input logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    // Offer one sample on the next edge, then sample outputs 1 ns after it.
    task automatic send(input logic [7:0] d, input logic ack);
        in_data   = d;
        in_valid  = 1'b1;
        frame_ack = ack;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_cycle();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; clear = 1'b0; frame_ack = 1'b0;
        #12;
        check("rst_data", fd_n, 64'h0);
        check("rst_valid", {63'h0, fv_n}, 64'h0);
        check("rst_fill", {61'h0, fc_n}, 64'h0);
        check("rst_ovf", {63'h0, ov_n}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1/2: contiguous frame 0x10..0x17
        for (int i = 0; i < 7; i++) begin
            send(8'(8'h10 + i), 1'b0);
            check("s1_fill", {61'h0, fc_n}, 64'(i + 1));
        end
        check("s1_not_yet_valid", {63'h0, fv_n}, 64'h0);
        send(8'h17, 1'b0);
        check("s1_valid", {63'h0, fv_n}, 64'h1);
        check("s1_fill_wrap", {61'h0, fc_n}, 64'h0);
        check("s1_nat", fd_n, pk(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17));
        check("s2_rev", fd_r, pk(8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17));
        check("s2_rev_valid", {63'h0, fv_r}, 64'h1);
        ack_cycle();
        check("ack_clears", {63'h0, fv_n}, 64'h0);
        check("ack_keeps_data", fd_n, pk(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17));
        ack_cycle();
        check("ack_idle_ignored", {63'h0, fv_n}, 64'h0);

        // Scenario 3: strobes with gaps (1,0,0,...)
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h10 + i), 1'b0);
            if (i < 7) begin
                idle();
                idle();
                check("s3_fill_hold", {61'h0, fc_n}, 64'(i + 1));
            end
        end
        check("s3_valid", {63'h0, fv_n}, 64'h1);
        check("s3_nat", fd_n, pk(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17));
        check("s3_ovf", {63'h0, ov_n}, 64'h0);
        ack_cycle();

        // Scenario 4: 16 samples without ack
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            if (i == 7) begin
                check("s4_first_no_ovf", {63'h0, ov_n}, 64'h0);
                check("s4_first_data", fd_n, pk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07));
            end
        end
        check("s4_ovf", {63'h0, ov_n}, 64'h1);
        check("s4_valid", {63'h0, fv_n}, 64'h1);
        check("s4_nat", fd_n, pk(8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F));
        check("s4_rev", fd_r, pk(8'h08, 8'h0C, 8'h0A, 8'h0E, 8'h09, 8'h0D, 8'h0B, 8'h0F));
        idle();
        check("s4_ovf_sticky", {63'h0, ov_n}, 64'h1);
        send(8'hEE, 1'b0);
        check("s4_partial", {61'h0, fc_n}, 64'h1);
        clear = 1'b1; in_data = 8'hEF; in_valid = 1'b1;
        idle();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_ovf", {63'h0, ov_n}, 64'h0);
        check("clr_valid", {63'h0, fv_n}, 64'h0);
        check("clr_fill", {61'h0, fc_n}, 64'h0);
        check("clr_data_kept", fd_n, pk(8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F));

        // Scenario 5: ack coincides with completion of frame 2
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1'b0);
        check("s5_f1_valid", {63'h0, fv_n}, 64'h1);
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), (i == 7) ? 1'b1 : 1'b0);
        check("s5_valid_stays", {63'h0, fv_n}, 64'h1);
        check("s5_no_ovf", {63'h0, ov_n}, 64'h0);
        check("s5_f2_data", fd_n, pk(8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37));

        // Scenario 6: asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0);
        check("s6_fill5", {61'h0, fc_n}, 64'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_data", fd_n, 64'h0);
        check("s6_async_rev", fd_r, 64'h0);
        check("s6_async_valid", {63'h0, fv_n}, 64'h0);
        check("s6_async_fill", {61'h0, fc_n}, 64'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 1'b0);
        check("s6_valid", {63'h0, fv_n}, 64'h1);
        check("s6_nat", fd_n, pk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7));
        check("s6_rev", fd_r, pk(8'hA0, 8'hA4, 8'hA2, 8'hA6, 8'hA1, 8'hA5, 8'hA3, 8'hA7));
        check("s6_ovf", {63'h0, ov_n}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
